// File: rtl/i2c_master_byte_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : i2c_master_byte_sequencer
// Purpose  : Turns one byte request into START / 8 data bits / ACK / STOP bit
//            commands for the I2C bit controller, and assembles the received
//            byte. Define I2C_BYTE_SEQ_TIMEOUT_EN for the bit-ack watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_master_byte_sequencer
`ifdef I2C_BYTE_SEQ_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYCLES = 65535
)
`endif
(
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Enable,
    input  logic       Start,
    input  logic       Stop,
    input  logic       Read,
    input  logic       Write,
    input  logic       Ack_in,
    input  logic [7:0] Din,
    output logic       Cmd_ack,
    output logic       Ack_out,
    output logic [7:0] Dout,
    output logic       Al,
    output logic [3:0] Bit_cmd,
    input  logic       Bit_ack,
    output logic       Bit_txd,
    input  logic       Bit_rxd,
    input  logic       Bit_al
`ifdef I2C_BYTE_SEQ_TIMEOUT_EN
    ,
    output logic       Timeout
`endif
);

    localparam logic [3:0] c_CMD_NOP   = 4'b0000;
    localparam logic [3:0] c_CMD_START = 4'b0001;
    localparam logic [3:0] c_CMD_STOP  = 4'b0010;
    localparam logic [3:0] c_CMD_WRITE = 4'b0100;
    localparam logic [3:0] c_CMD_READ  = 4'b1000;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_WRITE = 3'd2,
        S_READ  = 3'd3,
        S_ACK   = 3'd4,
        S_STOP  = 3'd5
    } state_t;

    state_t     r_state,   w_state_nxt;
    logic [7:0] r_shift,   w_shift_nxt;
    logic [2:0] r_cnt,     w_cnt_nxt;
    logic       r_al,      w_al_nxt;
    logic       r_ack_out, w_ack_out_nxt;
    logic       r_cmd_ack, w_cmd_ack_nxt;
    logic [3:0] r_bit_cmd, w_bit_cmd_nxt;
    logic       r_bit_txd, w_bit_txd_nxt;
    logic       w_go;
    logic       w_abort_tmo;

    // The pulse cycle of Cmd_ack must not relaunch on still-held requests
    assign w_go = (Read | Write | Stop) & ~r_cmd_ack;

`ifdef I2C_BYTE_SEQ_TIMEOUT_EN
    localparam logic [15:0] c_TMO_LIMIT = 16'(TIMEOUT_CYCLES);

    logic [15:0] r_tmo_cnt;
    logic        r_timeout;

    assign w_abort_tmo = (r_state != S_IDLE) && (r_tmo_cnt == c_TMO_LIMIT);

    always_ff @(posedge Clk) begin
        if (Rst || !Enable) begin
            r_tmo_cnt <= 16'd0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_abort_tmo && !Bit_al;
            if (r_state == S_IDLE || Bit_ack)
                r_tmo_cnt <= 16'd0;
            else
                r_tmo_cnt <= r_tmo_cnt + 16'd1;
        end
    end

    assign Timeout = r_timeout;
`else
    assign w_abort_tmo = 1'b0;
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_cnt_nxt     = r_cnt;
        w_al_nxt      = r_al;
        w_ack_out_nxt = r_ack_out;
        w_cmd_ack_nxt = 1'b0;
        w_bit_cmd_nxt = r_bit_cmd;
        w_bit_txd_nxt = r_bit_txd;

        if (Bit_al) begin
            w_state_nxt   = S_IDLE;
            w_bit_cmd_nxt = c_CMD_NOP;
            w_bit_txd_nxt = 1'b1;
            w_al_nxt      = 1'b1;
        end else if (w_abort_tmo) begin
            w_state_nxt   = S_IDLE;
            w_bit_cmd_nxt = c_CMD_NOP;
            w_bit_txd_nxt = 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_go) begin
                        w_shift_nxt   = Din;
                        w_cnt_nxt     = 3'd7;
                        w_al_nxt      = 1'b0;
                        w_bit_txd_nxt = 1'b1;
                        if (Start) begin
                            w_state_nxt   = S_START;
                            w_bit_cmd_nxt = c_CMD_START;
                        end else if (Read) begin
                            w_state_nxt   = S_READ;
                            w_bit_cmd_nxt = c_CMD_READ;
                        end else if (Write) begin
                            w_state_nxt   = S_WRITE;
                            w_bit_cmd_nxt = c_CMD_WRITE;
                            w_bit_txd_nxt = Din[7];
                        end else begin
                            w_state_nxt   = S_STOP;
                            w_bit_cmd_nxt = c_CMD_STOP;
                        end
                    end
                end
                S_START: begin
                    // Start+Stop without Read falls through to a write of Din
                    if (Bit_ack) begin
                        if (Read) begin
                            w_state_nxt   = S_READ;
                            w_bit_cmd_nxt = c_CMD_READ;
                            w_bit_txd_nxt = 1'b1;
                        end else begin
                            w_state_nxt   = S_WRITE;
                            w_bit_cmd_nxt = c_CMD_WRITE;
                            w_bit_txd_nxt = r_shift[7];
                        end
                    end
                end
                S_WRITE, S_READ: begin
                    if (Bit_ack) begin
                        w_shift_nxt = {r_shift[6:0], Bit_rxd};
                        if (r_cnt != 3'd0) begin
                            w_cnt_nxt     = r_cnt - 3'd1;
                            w_bit_txd_nxt = (r_state == S_WRITE) ? r_shift[6] : 1'b1;
                        end else begin
                            w_state_nxt = S_ACK;
                            if (r_state == S_READ) begin
                                w_bit_cmd_nxt = c_CMD_WRITE;
                                w_bit_txd_nxt = Ack_in;
                            end else begin
                                w_bit_cmd_nxt = c_CMD_READ;
                                w_bit_txd_nxt = 1'b1;
                            end
                        end
                    end
                end
                S_ACK: begin
                    if (Bit_ack) begin
                        w_ack_out_nxt = Bit_rxd;
                        w_bit_txd_nxt = 1'b1;
                        if (Stop) begin
                            w_state_nxt   = S_STOP;
                            w_bit_cmd_nxt = c_CMD_STOP;
                        end else begin
                            w_state_nxt   = S_IDLE;
                            w_bit_cmd_nxt = c_CMD_NOP;
                            w_cmd_ack_nxt = 1'b1;
                        end
                    end
                end
                S_STOP: begin
                    if (Bit_ack) begin
                        w_state_nxt   = S_IDLE;
                        w_bit_cmd_nxt = c_CMD_NOP;
                        w_bit_txd_nxt = 1'b1;
                        w_cmd_ack_nxt = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt   = S_IDLE;
                    w_bit_cmd_nxt = c_CMD_NOP;
                    w_bit_txd_nxt = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst || !Enable) begin
            r_state   <= S_IDLE;
            r_shift   <= 8'h00;
            r_cnt     <= 3'd0;
            r_al      <= 1'b0;
            r_ack_out <= 1'b0;
            r_cmd_ack <= 1'b0;
            r_bit_cmd <= c_CMD_NOP;
            r_bit_txd <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_cnt     <= w_cnt_nxt;
            r_al      <= w_al_nxt;
            r_ack_out <= w_ack_out_nxt;
            r_cmd_ack <= w_cmd_ack_nxt;
            r_bit_cmd <= w_bit_cmd_nxt;
            r_bit_txd <= w_bit_txd_nxt;
        end
    end

    assign Cmd_ack = r_cmd_ack;
    assign Ack_out = r_ack_out;
    assign Dout    = r_shift;
    assign Al      = r_al;
    assign Bit_cmd = r_bit_cmd;
    assign Bit_txd = r_bit_txd;

endmodule
`default_nettype wire

// File: tb/tb_i2c_master_byte_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_master_byte_sequencer
// Purpose  : Scoreboard bench: a reactive bit-controller model plus a monitor
//            compare the sequencer against a request-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_master_byte_sequencer;

    localparam logic [3:0] NOP   = 4'b0000;
    localparam logic [3:0] START = 4'b0001;
    localparam logic [3:0] STOP  = 4'b0010;
    localparam logic [3:0] WRITE = 4'b0100;
    localparam logic [3:0] READ  = 4'b1000;

    logic       Clk = 1'b0, Rst = 1'b1, Enable = 1'b1;
    logic       Start = 1'b0, Stop = 1'b0, Read = 1'b0, Write = 1'b0, Ack_in = 1'b0;
    logic [7:0] Din = 8'h00;
    logic       Cmd_ack, Ack_out, Al, Bit_txd;
    logic [7:0] Dout;
    logic [3:0] Bit_cmd;
    logic       Bit_ack = 1'b0, Bit_rxd = 1'b0, bm_al = 1'b0, drv_al = 1'b0;
    logic       w_bit_al;
    assign w_bit_al = bm_al | drv_al;
`ifdef I2C_BYTE_SEQ_TIMEOUT_EN
    logic       Timeout;
`endif

    typedef struct { logic [3:0] cmd; logic txd; logic rxd; bit chk_txd; } bitop_t;
    typedef struct { int kind; logic [7:0] dout; logic ack_out; } resp_t;
    typedef struct { bit start; bit stop; bit rd; bit wr; bit ack_in;
                     logic [7:0] din; logic [7:0] rx; logic ackbit; } req_t;

    bitop_t bitq[$];
    resp_t  respq[$];
    logic   m_ack_out = 1'b0;
    int     n_tests = 0, n_fail = 0, cyc = 0;
    int     ack_num = 0, al_on_ack = 0, last_ack_cyc = -10;
    bit     hold_acks = 1'b0;

`ifdef I2C_BYTE_SEQ_TIMEOUT_EN
    i2c_master_byte_sequencer #(.TIMEOUT_CYCLES(20)) dut (
`else
    i2c_master_byte_sequencer dut (
`endif
        .Clk(Clk), .Rst(Rst), .Enable(Enable), .Start(Start), .Stop(Stop),
        .Read(Read), .Write(Write), .Ack_in(Ack_in), .Din(Din),
        .Cmd_ack(Cmd_ack), .Ack_out(Ack_out), .Dout(Dout), .Al(Al),
        .Bit_cmd(Bit_cmd), .Bit_ack(Bit_ack), .Bit_txd(Bit_txd),
        .Bit_rxd(Bit_rxd), .Bit_al(w_bit_al)
`ifdef I2C_BYTE_SEQ_TIMEOUT_EN
        , .Timeout(Timeout)
`endif
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: expected bit-command stream and final response of one request
    task automatic model_req(input req_t r, input int kind);
        bit data;
        bitop_t b;
        resp_t e;
        data = r.rd | r.wr | r.start;
        if (r.start) begin b = '{START, 1'b1, 1'b0, 1'b0}; bitq.push_back(b); end
        for (int i = 0; i < 8; i++) begin
            if (r.rd) begin b = '{READ, 1'b1, r.rx[7-i], 1'b0}; bitq.push_back(b); end
            else if (data) begin b = '{WRITE, r.din[7-i], r.rx[7-i], 1'b1}; bitq.push_back(b); end
        end
        if (data) begin
            b = '{(r.rd ? WRITE : READ), (r.rd ? r.ack_in : 1'b1), r.ackbit, 1'b1};
            bitq.push_back(b);
            if (kind == 0) m_ack_out = r.ackbit;
        end
        if (r.stop) begin b = '{STOP, 1'b1, 1'b0, 1'b0}; bitq.push_back(b); end
        e.kind = kind;
        e.dout = data ? r.rx : r.din;
        e.ack_out = m_ack_out;
        if (kind != 2) respq.push_back(e);
    endtask

    // Bit-controller model: acks each command after a random delay
    initial begin : bit_model
        bit busy;
        logic [3:0] cur_cmd;
        logic cur_txd, rx;
        int dly;
        bitop_t b;
        busy = 1'b0; cur_cmd = NOP; cur_txd = 1'b1; rx = 1'b0; dly = 0;
        forever begin
            @(negedge Clk);
            Bit_ack = 1'b0;
            bm_al = 1'b0;
            if (Bit_cmd == NOP) begin
                busy = 1'b0;
            end else begin
                if (!busy) begin
                    busy = 1'b1; cur_cmd = Bit_cmd; cur_txd = Bit_txd;
                    dly = $urandom_range(0, 3);
                    if (bitq.size() == 0) begin
                        check("unexpected_bit_cmd", 32'(Bit_cmd), 32'(NOP));
                        rx = 1'b0;
                    end else begin
                        b = bitq.pop_front();
                        check("bit_cmd", 32'(Bit_cmd), 32'(b.cmd));
                        if (b.chk_txd) check("bit_txd", 32'(Bit_txd), 32'(b.txd));
                        rx = b.rxd;
                    end
                end else if (Bit_cmd !== cur_cmd || Bit_txd !== cur_txd) begin
                    check("cmd_hold", 32'({Bit_cmd, Bit_txd}), 32'({cur_cmd, cur_txd}));
                end
                if (!hold_acks) begin
                    if (dly == 0) begin
                        Bit_ack = 1'b1;
                        Bit_rxd = rx;
                        ack_num++;
                        last_ack_cyc = cyc + 1;
                        if (ack_num == al_on_ack) bm_al = 1'b1;
                        busy = 1'b0;
                    end else begin
                        dly--;
                    end
                end
            end
        end
    end

    initial begin : monitor
        logic al_q;
        resp_t e;
        al_q = 1'b0;
        forever begin
            @(negedge Clk);
            if (Cmd_ack) begin
                if (respq.size() == 0) check("unexpected_cmd_ack", 32'(Cmd_ack), 32'd0);
                else begin
                    e = respq.pop_front();
                    check("cmd_ack_expected", 32'(e.kind), 32'd0);
                    check("dout", 32'(Dout), 32'(e.dout));
                    check("ack_out", 32'(Ack_out), 32'(e.ack_out));
                    check("al_at_cmd_ack", 32'(Al), 32'd0);
                    check("cmd_ack_latency", 32'(cyc), 32'(last_ack_cyc));
                end
            end
            if (Al && !al_q) begin
                if (respq.size() == 0) check("unexpected_al", 32'(Al), 32'd0);
                else begin
                    e = respq.pop_front();
                    check("al_expected", 32'(e.kind), 32'd1);
                    check("al_bit_cmd", 32'(Bit_cmd), 32'(NOP));
                    check("al_txd", 32'(Bit_txd), 32'd1);
                    check("al_no_cmd_ack", 32'(Cmd_ack), 32'd0);
                end
            end
            al_q = Al;
        end
    end

    task automatic drive(input req_t r);
        Start = r.start; Stop = r.stop; Read = r.rd; Write = r.wr;
        Ack_in = r.ack_in; Din = r.din;
    endtask

    task automatic release_req();
        Start = 1'b0; Stop = 1'b0; Read = 1'b0; Write = 1'b0;
    endtask

    task automatic run_req(input req_t r, input int al_at);
        bit done;
        model_req(r, (al_at != 0) ? 1 : 0);
        @(negedge Clk);
        ack_num = 0; al_on_ack = al_at;
        drive(r);
        @(negedge Clk);
        check("al_cleared_on_go", 32'(Al), 32'd0);
        done = 1'b0;
        for (int k = 0; k < 500 && !done; k++) begin
            if (Cmd_ack || Al) done = 1'b1;
            else @(negedge Clk);
        end
        check("req_done", 32'(done), 32'd1);
        if (Cmd_ack) begin
            @(negedge Clk);
            check("no_relaunch", 32'(Bit_cmd), 32'(NOP));
            check("cmd_ack_pulse", 32'(Cmd_ack), 32'd0);
            release_req();
            check("bitq_drained", 32'(bitq.size()), 32'd0);
        end else begin
            release_req();
            @(negedge Clk);
            check("al_held", 32'(Al), 32'd1);
            check("al_idle_nop", 32'(Bit_cmd), 32'(NOP));
        end
        bitq.delete();
        al_on_ack = 0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_bit_cmd"}, 32'(Bit_cmd), 32'(NOP));
        check({tag, "_bit_txd"}, 32'(Bit_txd), 32'd1);
        check({tag, "_cmd_ack"}, 32'(Cmd_ack), 32'd0);
        check({tag, "_ack_out"}, 32'(Ack_out), 32'd0);
        check({tag, "_dout"}, 32'(Dout), 32'd0);
        check({tag, "_al"}, 32'(Al), 32'd0);
`ifdef I2C_BYTE_SEQ_TIMEOUT_EN
        check({tag, "_timeout"}, 32'(Timeout), 32'd0);
`endif
    endtask

    task automatic abort_mid(input bit use_rst, input req_t r, input int at_ack);
        bit hit;
        model_req(r, 2);
        @(negedge Clk);
        ack_num = 0;
        drive(r);
        hit = 1'b0;
        for (int k = 0; k < 200 && !hit; k++) begin
            @(negedge Clk);
            if (ack_num >= at_ack) hit = 1'b1;
        end
        check("abort_point_reached", 32'(hit), 32'd1);
        if (use_rst) Rst = 1'b1; else Enable = 1'b0;
        release_req();
        @(negedge Clk);
        check_reset_vals(use_rst ? "rst_mid" : "en_mid");
        Rst = 1'b0; Enable = 1'b1;
        bitq.delete();
        m_ack_out = 1'b0;
    endtask

    initial begin : driver
        req_t r;
        int t;
        repeat (3) @(negedge Clk);
        check_reset_vals("reset");
        Rst = 1'b0;

        // Start alone must never launch
        Start = 1'b1;
        repeat (5) @(negedge Clk);
        check("start_alone_nop", 32'(Bit_cmd), 32'(NOP));
        Start = 1'b0;

        r = '{start:1, stop:0, rd:0, wr:1, ack_in:0, din:8'hA5, rx:8'hA5, ackbit:1'b0};
        run_req(r, 0);
        r = '{start:0, stop:1, rd:1, wr:0, ack_in:1, din:8'h00, rx:8'h3C, ackbit:1'b1};
        run_req(r, 0);
        r = '{start:0, stop:0, rd:0, wr:1, ack_in:0, din:8'hFF, rx:8'hFF, ackbit:1'b0};
        run_req(r, 3);
        r = '{start:0, stop:0, rd:0, wr:1, ack_in:0, din:8'h81, rx:8'h18, ackbit:1'b1};
        run_req(r, 0);

        r = '{start:0, stop:0, rd:1, wr:0, ack_in:0, din:8'h00, rx:8'hC3, ackbit:1'b0};
        abort_mid(1'b1, r, 4);
        r = '{start:0, stop:0, rd:0, wr:1, ack_in:0, din:8'h6B, rx:8'h6B, ackbit:1'b0};
        abort_mid(1'b0, r, 3);

        r = '{start:0, stop:1, rd:0, wr:0, ack_in:0, din:8'h5A, rx:8'h00, ackbit:1'b0};
        run_req(r, 0);
        r = '{start:1, stop:1, rd:1, wr:1, ack_in:0, din:8'h11, rx:8'h96, ackbit:1'b0};
        run_req(r, 0);
        r = '{start:1, stop:1, rd:0, wr:0, ack_in:0, din:8'hE7, rx:8'h2D, ackbit:1'b1};
        run_req(r, 0);

        // Arbitration loss while idle
        begin
            resp_t e;
            e = '{1, 8'h00, 1'b0};
            respq.push_back(e);
            @(negedge Clk); drv_al = 1'b1;
            @(negedge Clk); drv_al = 1'b0;
            @(negedge Clk);
            check("idle_al_set", 32'(Al), 32'd1);
        end
        r = '{start:0, stop:0, rd:1, wr:0, ack_in:0, din:8'h00, rx:8'h77, ackbit:1'b1};
        run_req(r, 0);

        // Bit controller never acks
        begin
            bitop_t b;
            int t0, got;
            hold_acks = 1'b1;
            b = '{WRITE, 1'b1, 1'b0, 1'b1};
            bitq.push_back(b);
            @(negedge Clk);
            Write = 1'b1; Din = 8'h80;
            t0 = cyc + 1;
`ifdef I2C_BYTE_SEQ_TIMEOUT_EN
            got = -1;
            for (int k = 0; k < 200 && got < 0; k++) begin
                @(negedge Clk);
                if (Timeout) got = cyc - t0;
            end
            Write = 1'b0;
            check("timeout_cycle", 32'(got), 32'd21);
            check("timeout_nop", 32'(Bit_cmd), 32'(NOP));
            @(negedge Clk);
            check("timeout_pulse", 32'(Timeout), 32'd0);
            check("timeout_idle", 32'(Bit_cmd), 32'(NOP));
`else
            repeat (100) @(negedge Clk);
            got = cyc - t0;
            check("stretch_held_write", 32'(Bit_cmd), 32'(WRITE));
            check("stretch_no_cmd_ack", 32'(Cmd_ack), 32'd0);
            Write = 1'b0; Rst = 1'b1;
            @(negedge Clk);
            Rst = 1'b0;
            m_ack_out = 1'b0;
`endif
            bitq.delete();
            hold_acks = 1'b0;
        end

        for (int i = 0; i < 40; i++) begin
            t = $urandom_range(0, 3);
            r.start  = 1'($urandom_range(0, 1));
            r.stop   = (t == 3) ? 1'b1 : 1'($urandom_range(0, 1));
            r.rd     = (t == 0) || (t == 2);
            r.wr     = (t == 1) || (t == 2);
            r.ack_in = 1'($urandom_range(0, 1));
            r.din    = 8'($urandom);
            r.rx     = 8'($urandom);
            r.ackbit = 1'($urandom_range(0, 1));
            run_req(r, ((i % 10) == 7) ? int'($urandom_range(1, 4)) : 0);
        end

        repeat (5) @(negedge Clk);
        check("respq_empty", 32'(respq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
